// File: rtl/demux_rr_pkg.sv
// ---------------------------------------------------------------------------
// demux_rr_pkg
// Shared types and helpers for the round-robin demux dispatcher.
//   state_t   : dispatcher FSM state (IDLE = output register empty,
//               HOLD = output register holds an undelivered beat)
//   MAX_N     : largest channel count the search helper supports
//   next_idx  : wrap-around increment of a channel index
//   rr_pick   : first enabled channel at or after a pointer, -1 if none
// ---------------------------------------------------------------------------
package demux_rr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // The search helper works on a fixed-width enable vector so it can be
    // shared by dispatchers of any size; callers zero-extend their enables.
    localparam int MAX_SW = 8;
    localparam int MAX_N  = 1 << MAX_SW;

    // Advance a channel index by one, wrapping n-1 back to 0.
    function automatic int next_idx(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

    // Walk ptr, ptr+1, ... (wrapping at n) and return the first index whose
    // enable bit is set. Only the first n steps are meaningful, the rest of
    // the fixed-length loop is masked off.
    function automatic int rr_pick(input int ptr, input logic [MAX_N-1:0] en,
                                   input int n);
        int idx;
        int found;
        found = -1;
        idx   = ptr;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                if (found < 0 && en[idx[MAX_SW-1:0]]) begin
                    found = idx;
                end
                idx = next_idx(idx, n);
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/demux_onehot_dec.sv
// ---------------------------------------------------------------------------
// demux_onehot_dec
// Decodes a channel select plus an enable into an N-bit one-hot vector.
// This is the same decode the demux datapath uses for its write strobes.
//   sel    : channel index to assert
//   en     : when low, every output bit is zero
//   onehot : bit sel is set when en is high, all others clear
// ---------------------------------------------------------------------------
module demux_onehot_dec #(
    parameter int N  = 64,
    parameter int SW = $clog2(N)
) (
    input  logic [SW-1:0] sel,
    input  logic          en,
    output logic [N-1:0]  onehot
);

    // One comparator per channel; at most one can match a given sel.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = en && (sel == SW'(i));
        end
    end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// ---------------------------------------------------------------------------
// demux_rr_dispatcher
// Round-robin scheduler that spreads one valid/ready stream over N channels
// sharing a single output data bus.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   chan_en   [N]       : per-channel enable; disabled channels are skipped
//   in_valid/in_data/in_ready : upstream beat handshake
//   out_valid [N]       : one-hot valid towards the selected channel
//   out_data  [W]       : shared output data bus
//   out_ready [N]       : per-channel ready, only the selected bit matters
//   sel       [SW]      : index of the channel currently driven
//   busy                : output register holds an undelivered beat
//   beat_cnt  [CW]      : delivered-beat counter, wraps modulo 2^CW
// ---------------------------------------------------------------------------
module demux_rr_dispatcher
    import demux_rr_pkg::*;
#(
    parameter int N  = 64,
    parameter int W  = 8,
    parameter int SW = $clog2(N),
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  chan_en,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic [N-1:0]  out_valid,
    output logic [W-1:0]  out_data,
    input  logic [N-1:0]  out_ready,
    output logic [SW-1:0] sel,
    output logic          busy,
    output logic [CW-1:0] beat_cnt
);

    state_t        state;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] pick;
    logic          no_target;
    logic          accept;
    logic          deliver;
    int            pick_idx;

    // Choose the next destination and decide whether a beat can be taken.
    // While holding, a new beat is only taken if the held one leaves this
    // same cycle, which gives full throughput without a second register.
    always_comb begin
        pick_idx  = rr_pick(int'(rr_ptr), MAX_N'(chan_en), N);
        no_target = (pick_idx < 0);
        pick      = no_target ? '0 : SW'(pick_idx);
        deliver   = (state == HOLD) && out_ready[sel];
        if (state == HOLD) begin
            in_ready = out_ready[sel] && !no_target;
        end else begin
            in_ready = !no_target;
        end
        accept = in_valid && in_ready;
    end

    // FSM, output register, round-robin pointer and delivery counter.
    // A held beat keeps its sel even if its channel is disabled meanwhile;
    // only future picks see the new enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            out_data <= '0;
            sel      <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            if (deliver) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (deliver && !accept) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                out_data <= in_data;
                sel      <= pick;
                rr_ptr   <= SW'(next_idx(int'(pick), N));
            end
        end
    end

    assign busy = (state == HOLD);

    demux_onehot_dec #(
        .N  (N),
        .SW (SW)
    ) u_dec (
        .sel    (sel),
        .en     (busy),
        .onehot (out_valid)
    );

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_demux_rr_dispatcher
// Drives a 4-channel and a 5-channel dispatcher (the latter with a 4-bit
// counter so wrap-around is reachable) from the same stimulus and compares
// both against a per-beat reference model every cycle.
// ---------------------------------------------------------------------------
module tb_demux_rr_dispatcher;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] chan_en;
    logic [4:0] out_ready;
    logic       in_valid;
    logic [W-1:0] in_data;

    logic         in_ready4, busy4;
    logic [3:0]   out_valid4;
    logic [W-1:0] out_data4;
    logic [1:0]   sel4;
    logic [15:0]  beat_cnt4;

    logic         in_ready5, busy5;
    logic [4:0]   out_valid5;
    logic [W-1:0] out_data5;
    logic [2:0]   sel5;
    logic [3:0]   beat_cnt5;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state, index 0 = 4-channel DUT, index 1 = 5-channel DUT.
    int nch[2]     = '{4, 5};
    int cnt_mod[2] = '{65536, 16};
    int m_ptr[2];
    int m_held[2];
    int m_sel[2];
    int m_data[2];
    int m_cnt[2];

    // Free-running clock.
    always #5 clk = ~clk;

    demux_rr_dispatcher #(.N(4), .W(W), .CW(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .chan_en(chan_en[3:0]),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_data(out_data4),
        .out_ready(out_ready[3:0]), .sel(sel4), .busy(busy4),
        .beat_cnt(beat_cnt4)
    );

    demux_rr_dispatcher #(.N(5), .W(W), .CW(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .chan_en(chan_en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready5),
        .out_valid(out_valid5), .out_data(out_data5),
        .out_ready(out_ready), .sel(sel5), .busy(busy5),
        .beat_cnt(beat_cnt5)
    );

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reset empties the model: nothing held, pointer, sel, data, count at 0.
    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_held[d] = 0; m_sel[d] = 0; m_data[d] = 0; m_cnt[d] = 0;
        end
    endtask

    // First enabled channel scanning from the model pointer, -1 if none.
    function automatic int modelPick(input int d);
        for (int k = 0; k < nch[d]; k++) begin
            int c;
            c = (m_ptr[d] + k) % nch[d];
            if (chan_en[c]) return c;
        end
        return -1;
    endfunction

    // Compare one DUT against the model for the current cycle, then (unless
    // reset is holding everything) advance the model across the coming edge.
    task automatic checkCycle(input int d, input bit advance);
        int    pk;
        bit    exp_ready, deliver, accept;
        string p;
        pk        = modelPick(d);
        exp_ready = (pk >= 0) && (!m_held[d] || out_ready[m_sel[d]]);
        p         = $sformatf("n%0d_", nch[d]);
        checkOutput({p, "in_ready"},  32'(d == 0 ? in_ready4 : in_ready5), 32'(exp_ready));
        checkOutput({p, "busy"},      32'(d == 0 ? busy4 : busy5), 32'(m_held[d]));
        checkOutput({p, "sel"},       d == 0 ? 32'(sel4) : 32'(sel5), 32'(m_sel[d]));
        checkOutput({p, "out_valid"}, d == 0 ? 32'(out_valid4) : 32'(out_valid5),
                    m_held[d] ? (32'd1 << m_sel[d]) : 32'd0);
        checkOutput({p, "out_data"},  d == 0 ? 32'(out_data4) : 32'(out_data5), 32'(m_data[d]));
        checkOutput({p, "beat_cnt"},  d == 0 ? 32'(beat_cnt4) : 32'(beat_cnt5), 32'(m_cnt[d]));
        if (advance) begin
            deliver = m_held[d] && out_ready[m_sel[d]];
            accept  = in_valid && exp_ready;
            if (deliver) m_cnt[d] = (m_cnt[d] + 1) % cnt_mod[d];
            if (accept) begin
                m_held[d] = 1; m_sel[d] = pk; m_data[d] = in_data;
                m_ptr[d]  = (pk + 1) % nch[d];
            end else if (deliver) begin
                m_held[d] = 0;
            end
        end
    endtask

    // One clock of stimulus: drive on the falling edge, check shortly after.
    task automatic applyStimulus(input bit v, input logic [W-1:0] data,
                                 input logic [4:0] en, input logic [4:0] rdy);
        @(negedge clk);
        in_valid = v; in_data = data; chan_en = en; out_ready = rdy;
        #1;
        checkCycle(0, 1'b1);
        checkCycle(1, 1'b1);
    endtask

    // Assert reset with in_valid high and no channels enabled, check that
    // every output is cleared, then release with in_valid low.
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; chan_en = '0; out_ready = 5'h1f;
        modelReset();
        #1;
        checkCycle(0, 1'b0);
        checkCycle(1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        rst_n = 1'b1; in_valid = 1'b0; in_data = '0; chan_en = '0; out_ready = '0;
        modelReset();

        // Reset and idle: after release, ready as soon as a channel is enabled.
        doReset();
        applyStimulus(1'b0, 8'h00, 5'h1f, 5'h1f);
        checkOutput("idle_in_ready", 32'(in_ready4), 32'd1);

        // Round robin: 8 back-to-back beats, then one idle cycle to drain.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 5'h1f, 5'h1f);
        applyStimulus(1'b0, 8'h00, 5'h1f, 5'h1f);
        applyStimulus(1'b0, 8'h00, 5'h1f, 5'h1f);
        checkOutput("rr_beat_cnt", 32'(beat_cnt4), 32'd8);

        // Skip disabled channels: only 1 and 3 may be chosen.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(i), 5'b01010, 5'h1f);
            checkOutput("skip_mask", 32'(out_valid4 & 4'b0101), 32'd0);
        end
        applyStimulus(1'b0, 8'h00, 5'b01010, 5'h1f);
        checkOutput("skip_last_sel", 32'(sel4), 32'd3);

        // Backpressure: beat 0x5C parked on channel 2, then bypass 0x5D.
        doReset();
        applyStimulus(1'b1, 8'h50, 5'h1f, 5'h1f);
        applyStimulus(1'b1, 8'h51, 5'h1f, 5'h1f);
        applyStimulus(1'b1, 8'h5C, 5'h1f, 5'b11011);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h5D, 5'h1f, 5'b11011);
            checkOutput("bp_sel", 32'(sel4), 32'd2);
            checkOutput("bp_data", 32'(out_data4), 32'h5C);
            checkOutput("bp_in_ready", 32'(in_ready4), 32'd0);
            checkOutput("bp_cnt", 32'(beat_cnt4), 32'd2);
        end
        applyStimulus(1'b1, 8'h5D, 5'h1f, 5'h1f);
        applyStimulus(1'b0, 8'h00, 5'h1f, 5'h1f);
        checkOutput("bp_next_sel", 32'(sel4), 32'd3);
        checkOutput("bp_next_data", 32'(out_data4), 32'h5D);

        // No target: nothing accepted until channel 2 is enabled.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h77, 5'h00, 5'h1f);
        applyStimulus(1'b1, 8'h78, 5'b00100, 5'h1f);
        applyStimulus(1'b0, 8'h00, 5'b00100, 5'h1f);
        checkOutput("nt_sel", 32'(sel4), 32'd2);

        // Non-power-of-two wrap, then reset in the middle of a hold.
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h30 + 8'(i), 5'h1f, 5'h1f);
        applyStimulus(1'b1, 8'h3F, 5'h1f, 5'h00);
        checkOutput("n5_wrap_sel", 32'(sel5), 32'd0);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("mid_rst_busy", 32'(busy5), 32'd0);
        checkOutput("mid_rst_valid", 32'(out_valid5), 32'd0);
        checkCycle(0, 1'b0);
        checkCycle(1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        applyStimulus(1'b1, 8'h44, 5'h1f, 5'h1f);
        applyStimulus(1'b0, 8'h00, 5'h1f, 5'h1f);
        checkOutput("post_rst_sel", 32'(sel5), 32'd0);
        checkOutput("post_rst_cnt", 32'(beat_cnt5), 32'd0);

        // Randomized traffic with changing enables and ready patterns; long
        // enough for the 4-bit counter to wrap several times.
        doReset();
        for (int i = 0; i < 600; i++) begin
            logic [4:0] en;
            en = (i % 20 == 0 && $urandom_range(0, 3) == 0) ? 5'h00 :
                 5'($urandom_range(1, 31));
            if (i % 8 != 0) en = chan_en;
            if (en == 5'h00 && i % 20 != 0) en = 5'h1f;
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom),
                          en, 5'($urandom) | 5'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
